// File: rtl/difficulty_encoder_pkg.sv
// Shared difficulty-code definitions: widths, FSM states and the
// saturate-to-code helper also used by the difficulty mapping side.
package difficulty_encoder_pkg;

  localparam int unsigned DIFF_CODE_W   = 4;
  localparam int unsigned DIFF_CODE_MAX = 15;
  localparam int unsigned HASH_W        = 256;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  function automatic logic [DIFF_CODE_W-1:0] lz_to_code(input logic [8:0] lz);
    if (lz > 9'(DIFF_CODE_MAX)) begin
      return DIFF_CODE_W'(DIFF_CODE_MAX);
    end
    return lz[DIFF_CODE_W-1:0];
  endfunction

endpackage

// File: rtl/difficulty_encoder_lzc.sv
// Combinational leading-zero count of one hash word; an all-zero word
// yields WORD_W.
module leading_zero_count #(
  parameter int unsigned WORD_W = 32
) (
  input  logic [WORD_W-1:0]       word_i,
  output logic [$clog2(WORD_W):0] count_o
);

  // Scan LSB to MSB so the highest set bit is the last assignment to win.
  always_comb begin
    count_o = ($clog2(WORD_W) + 1)'(WORD_W);
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (word_i[i]) begin
        count_o = ($clog2(WORD_W) + 1)'(WORD_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/difficulty_encoder.sv
// Counts leading zeros of a streamed hash (MSW first) and encodes them as a
// 4-bit difficulty code. Optional best-code tracker: DIFFICULTY_BEST_EN.
module difficulty_encoder
  import difficulty_encoder_pkg::*;
#(
  parameter int unsigned WORDS  = 8,
  parameter int unsigned WORD_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DIFF_CODE_W-1:0] target,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_W-1:0]      in_word,
  output logic                   out_valid,
  output logic [8:0]             out_lz,
  output logic [DIFF_CODE_W-1:0] out_code,
  output logic                   out_match,
  input  logic                   best_clr,
  output logic [DIFF_CODE_W-1:0] best_code
);

  localparam int unsigned BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CLZ_W  = $clog2(WORD_W) + 1;

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [8:0]             lz_q, lz_d;
  logic                   still_zero_q, still_zero_d;
  logic [DIFF_CODE_W-1:0] target_q, target_d;
  logic [8:0]             out_lz_q, out_lz_d;
  logic [DIFF_CODE_W-1:0] out_code_q, out_code_d;
  logic                   out_match_q, out_match_d;
  logic [CLZ_W-1:0]       clz;
  logic                   accept;

  leading_zero_count #(.WORD_W(WORD_W)) u_lzc (
    .word_i  (in_word),
    .count_o (clz)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      lz_q         <= '0;
      still_zero_q <= 1'b1;
      target_q     <= '0;
      out_lz_q     <= '0;
      out_code_q   <= '0;
      out_match_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      lz_q         <= lz_d;
      still_zero_q <= still_zero_d;
      target_q     <= target_d;
      out_lz_q     <= out_lz_d;
      out_code_q   <= out_code_d;
      out_match_q  <= out_match_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    lz_d         = lz_q;
    still_zero_d = still_zero_q;
    target_d     = target_q;
    out_lz_d     = out_lz_q;
    out_code_d   = out_code_q;
    out_match_d  = out_match_q;
    in_ready     = (state_q != DONE);
    out_valid    = (state_q == DONE);
    accept       = in_valid & in_ready;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          target_d     = target;
          lz_d         = 9'(clz);
          still_zero_d = (in_word == '0);
          beat_d       = BEAT_W'(1);
          state_d      = (WORDS == 1) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (accept) begin
          if (still_zero_q) begin
            lz_d = lz_q + 9'(clz);
          end
          still_zero_d = still_zero_q & (in_word == '0);
          beat_d       = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(WORDS - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d      = IDLE;
        beat_d       = '0;
        still_zero_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Result registers load from the just-finished accumulation on DONE entry.
    if (state_d == DONE && state_q != DONE) begin
      out_lz_d    = lz_d;
      out_code_d  = lz_to_code(lz_d);
      out_match_d = (out_code_d >= target_d);
    end
  end

  assign out_lz    = out_lz_q;
  assign out_code  = out_code_q;
  assign out_match = out_match_q;

`ifdef DIFFICULTY_BEST_EN
  logic [DIFF_CODE_W-1:0] best_q, best_d;

  // A clear in the DONE cycle wins over capturing that frame's code.
  always_comb begin
    best_d = best_q;
    if (best_clr) begin
      best_d = '0;
    end else if (state_q == DONE && out_code_q > best_q) begin
      best_d = out_code_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_q <= '0;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_code = best_q;
`else
  logic unused_best_clr;
  assign unused_best_clr = best_clr;
  assign best_code       = '0;
`endif

endmodule

// File: tb/tb_difficulty_encoder.sv
// Randomized self-checking bench for difficulty_encoder against a whole-hash
// leading-zero reference model.
module tb_difficulty_encoder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   target;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         out_valid;
  logic [8:0]   out_lz;
  logic [3:0]   out_code;
  logic         out_match;
  logic         best_clr;
  logic [3:0]   best_code;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  int unsigned  pulses = 0;
  int unsigned  exp_pulses = 0;
  logic         prev_ov = 1'b0;
  int unsigned  exp_best = 0;
  logic [255:0] hashes[40];
  logic [3:0]   tgts[40];

  difficulty_encoder #(.WORDS(8), .WORD_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .target    (target),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_lz    (out_lz),
    .out_code  (out_code),
    .out_match (out_match),
    .best_clr  (best_clr),
    .best_code (best_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_lz(input logic [255:0] h);
    for (int i = 255; i >= 0; i--) begin
      if (h[i]) return 255 - i;
    end
    return 256;
  endfunction

  function automatic logic [255:0] mk_hash(input int unsigned k);
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    if (k >= 256) return '0;
    for (int i = 255; i > 255 - int'(k); i--) h[i] = 1'b0;
    h[255-k] = 1'b1;
    return h;
  endfunction

  // out_valid must be a single-cycle strobe; count every strobe seen.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        check_eq("ov_one_cycle", 32'(prev_ov), 0);
        pulses++;
      end
      prev_ov = out_valid;
    end
  end

  task automatic put_beat(input logic [31:0] w);
    int unsigned waited = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check_eq("ready_timeout", 0, 1);
    else @(negedge clk);
  endtask

  task automatic run_frame(input logic [255:0] h, input logic [3:0] tg,
                           input int unsigned gapmax, input bit b2b, input bit clr_at_done);
    int unsigned lz, code;
    lz   = ref_lz(h);
    code = (lz > 15) ? 15 : lz;
    for (int k = 0; k < 8; k++) begin
      target = (k == 0) ? tg : 4'($urandom);
      put_beat(h[255-32*k -: 32]);
      if (k < 7 && gapmax > 0) begin
        int unsigned gap = $urandom_range(0, gapmax);
        if (gap > 0) begin
          in_valid = 1'b0;
          in_word  = $urandom;
          repeat (gap) @(negedge clk);
        end
      end
    end
    in_valid = 1'b0;
    exp_pulses++;
    check_eq("out_valid", 32'(out_valid), 1);
    check_eq("out_lz", 32'(out_lz), lz);
    check_eq("out_code", 32'(out_code), code);
    check_eq("out_match", 32'(out_match), 32'(code >= tg));
    if (clr_at_done) best_clr = 1'b1;
`ifdef DIFFICULTY_BEST_EN
    if (clr_at_done) exp_best = 0;
    else if (code > exp_best) exp_best = code;
`endif
    if (!b2b) begin
      @(negedge clk);
      best_clr = 1'b0;
      check_eq("best_code", 32'(best_code), exp_best);
    end
  endtask

  initial begin
    logic [255:0] h;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_word  = '0;
    target   = '0;
    best_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_lz", 32'(out_lz), 0);
    check_eq("rst_out_code", 32'(out_code), 0);
    check_eq("rst_out_match", 32'(out_match), 0);
    check_eq("rst_best", 32'(best_code), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 1);

    // Directed corner frames.
    run_frame('0, 4'd15, 0, 0, 0);
    h = mk_hash(0);
    h[255 -: 32] = 32'h0800_0000;
    run_frame(h, 4'd5, 0, 0, 0);
    run_frame(h, 4'd4, 0, 0, 0);
    run_frame(h, 4'd0, 0, 0, 0);
    h = mk_hash(0);
    h[255 -: 32] = 32'h0;
    h[223 -: 32] = 32'h8000_0000;
    run_frame(h, 4'd15, 0, 0, 0);
    h = mk_hash(0);
    h[255 -: 32] = 32'h0001_0000;
    run_frame(h, 4'd15, 0, 0, 0);

    // Random frames gap-free, then replayed with gaps and held beats through DONE.
    for (int i = 0; i < 40; i++) begin
      hashes[i] = mk_hash(($urandom_range(0, 5) == 0) ? 256 : $urandom_range(0, 70));
      tgts[i]   = 4'($urandom);
      run_frame(hashes[i], tgts[i], 0, (i % 3) != 0, 0);
    end
    for (int i = 0; i < 40; i++) begin
      run_frame(hashes[i], tgts[i], 5, (i % 2) == 0, 0);
    end

    // Reset after three beats discards the partial frame.
    @(negedge clk);
    for (int k = 0; k < 3; k++) put_beat($urandom);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 0);
    check_eq("midrst_out_lz", 32'(out_lz), 0);
    check_eq("midrst_in_ready", 32'(in_ready), 1);
    exp_best = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_frame(mk_hash(9), 4'd9, 2, 0, 0);
    run_frame(mk_hash(40), 4'd3, 0, 0, 0);

    // Best-code tracking and clear precedence.
    best_clr = 1'b1;
    @(negedge clk);
    best_clr = 1'b0;
`ifdef DIFFICULTY_BEST_EN
    exp_best = 0;
`endif
    @(negedge clk);
    check_eq("best_clr", 32'(best_code), 0);
    run_frame(mk_hash(3), 4'd2, 0, 0, 0);
    run_frame(mk_hash(7), 4'd2, 0, 0, 0);
    run_frame(mk_hash(5), 4'd2, 0, 0, 0);
    best_clr = 1'b1;
    @(negedge clk);
    best_clr = 1'b0;
`ifdef DIFFICULTY_BEST_EN
    exp_best = 0;
`endif
    @(negedge clk);
    check_eq("best_clr2", 32'(best_code), 0);
    run_frame(mk_hash(6), 4'd1, 0, 0, 0);
    run_frame(mk_hash(9), 4'd1, 0, 0, 1);

    repeat (3) @(negedge clk);
    check_eq("pulse_count", pulses, exp_pulses);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/difficulty_encoder.md
# difficulty_encoder

Inverse of the difficulty mapping for the mining core. Consumes a SHA-256 double-hash result streamed as 32-bit words, most significant word first. Counts the hash's leading zero bits and encodes them into the same 4-bit difficulty code space, where code n means the top n bits must be zero. Compares that achieved code against the configured target code, and sits between the hash pipeline output and the nonce-report logic.

## Interface
Parameters:
- WORDS, 8, number of 32-bit beats per hash (256-bit result).
- WORD_W, 32, bits per beat.

Ports:
- clk  in  1  sole clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- target  in  4  required difficulty code; sampled on the first accepted beat of a frame.
- in_valid  in  1  beat valid.
- in_ready  out  1  block can accept a beat.
- in_word  in  WORD_W  hash word, MSW first.
- out_valid  out  1  one-cycle result strobe.
- out_lz  out  9  total leading zeros of the hash, 0..256.
- out_code  out  4  min(out_lz, 15).
- out_match  out  1  out_code >= sampled target.
- best_clr  in  1  clear best tracker (DIFFICULTY_BEST_EN only).
- best_code  out  4  highest out_code since clear (DIFFICULTY_BEST_EN only).

## Operation
- FSM states:
  - IDLE: in_ready=1. A beat is accepted when in_valid & in_ready. The first accepted beat latches target, clears the accumulators, processes word 0, sets beat=1, and moves to SCAN.
  - SCAN: in_ready=1. Each accepted beat increments beat. On the beat where beat==WORDS-1 is accepted, go to DONE.
  - DONE: in_ready=0, out_valid=1 for exactly one cycle, then IDLE.
- Accumulation:
  - A still_zero flag is set at frame start.
  - Per accepted beat: if still_zero, lz += clz(in_word), where clz(0)=32. still_zero clears on the first nonzero word.
  - Beats after the first nonzero word are consumed and ignored.
- Arithmetic:
  - lz is 9 bits. The maximum is exactly 256, so no overflow is possible.
  - out_code saturates at 15. out_match is an unsigned 4-bit compare against the latched target.
  - target=0 always matches.
- Gaps: in_valid low in IDLE or SCAN stalls with no state change. Arbitrary idle cycles between beats are legal.
- out_lz, out_code and out_match are registered. They are loaded on entry to DONE and hold until the next DONE.
- Reset values:
  - state IDLE; in_ready=1 once out of reset.
  - out_valid=0, out_lz=0, out_code=0, out_match=0, best_code=0.
  - beat=0, still_zero=1.
- Reset mid-frame: the partial frame is discarded with no out_valid. The next accepted beat is treated as word 0.
- Changing target mid-frame has no effect on that frame.

## Timing
- Result latency: out_valid asserts the cycle after the last beat is accepted.
- Throughput: one frame per WORDS+1 cycles. The DONE bubble is the only back-pressure.
- A beat presented during DONE is not accepted; the producer must hold it, per the valid/ready rule.
- Once asserted, in_valid and in_word must stay stable until accepted.
- in_ready depends only on state, with no combinational path from in_valid.

## Configuration
- DIFFICULTY_BEST_EN:
  - Defined: best_code register updates to max(best_code, out_code) in the DONE cycle.
  - best_clr zeroes it synchronously. If best_clr and DONE occur in the same cycle, the clear wins and best_code becomes 0; that frame's code is not captured.
  - Undefined: best_clr is ignored, best_code is tied to 0, and no register is inferred.

## Structure
- Shared package holds:
  - DIFF_CODE_W=4, DIFF_CODE_MAX=15, HASH_W=256.
  - FSM state enum {IDLE, SCAN, DONE}.
  - The saturate-to-code function, shared with the difficulty mapping users.
- One sub-module, leading_zero_count: combinational WORD_W-bit clz with a 6-bit result (32 for zero input).

## Test plan
- All-zero hash, target 15 -> out_lz=256, out_code=15, out_match=1. out_valid lasts exactly one cycle, one cycle after beat 8.
- word0=0x0800_0000, rest random, target 5 -> out_lz=4, out_code=4, out_match=0. Same frame with target 4 -> out_match=1.
- word0=0, word1=0x8000_0000 -> out_lz=32, out_code=15. word0=0x0001_0000 -> out_lz=15, out_code=15.
- Random in_valid gaps (0–5 cycles) and a beat held through DONE -> results identical to the gap-free run, and no beat is lost or duplicated.
- reset_n pulsed low after beat 3 -> no out_valid for that frame. The following 8 beats produce the correct result for that new hash.
- DIFFICULTY_BEST_EN, frames with codes 3, 7, 5 -> best_code=7. best_clr -> 0. best_clr coincident with DONE for a code-9 frame -> best_code=0.
